adc_spi_scan: RTL
=================

// Module: adc_spi_scan
// PURPOSE
//  SPI master that scans up to 8 channels of an external 16-bit ADC and holds the latest results for readback.
//  Sits upstream of the I2C register slave: drives its read-only bytes (ch n MSB/LSB -> ireg1c+2n / ireg1d+2n).
//  Is controlled by bits of the I2C write registers (start, continuous, channel mask).
//  Results are committed atomically per scan, so a multi-byte I2C read never mixes two scans.
// PARAMETERS
//  CLK_DIV  4   clk cycles per SCLK half-period (>=2)
//  CS_GAP   8   minimum clk cycles spi_csn stays high between frames (>=1)
// PORTS
//  clk         in   1    system clock
//  rstn        in   1    asynchronous active-low reset
//  i_start     in   1    scan request, level from register bit; rising edge detected internally
//  i_cont      in   1    1: rescan continuously; 0: single scan per i_start edge
//  i_ch_mask   in   8    bit n=1 enables channel n
//  spi_csn     out  1    ADC chip select, active low
//  spi_sclk    out  1    SPI clock, idle high
//  spi_mosi    out  1    command bit, changes on SCLK falling edge
//  spi_miso    in   1    ADC data, sampled on SCLK rising edge (2-FF synchronised)
//  o_busy      out  1    high from accepted start until the result commit cycle
//  o_done      out  1    1-cycle pulse on result commit
//  o_scan_cnt  out  8    completed scans, wraps 0xFF->0x00
//  o_ch_data   out  128  channel n result at [16n+15:16n]
// BEHAVIOUR
//  Reset
//  - spi_csn=1, spi_sclk=1, spi_mosi=0.
//  - o_busy=0, o_done=0, o_scan_cnt=0, o_ch_data=0, state IDLE.
//  - Reset asserted mid-frame aborts immediately; no partial commit.
//  Frame (16 SCLK)
//  - MOSI word {2'b00, ch[2:0], 11'b0}, MSB first, selects the channel converted NEXT.
//  - MISO returns the conversion selected by the previous frame (1-frame pipeline).
//  Scan
//  - For k enabled channels, issue k+1 frames in ascending channel order.
//  - Frame 1 result is discarded; the last frame's command re-addresses the lowest enabled channel.
//  - Results go to a shadow buffer; o_ch_data is copied from shadow for enabled channels only.
//  - Masked channels keep their old value.
//  FSM
//  - IDLE: on i_start rising edge, i_ch_mask!=0, not busy -> latch mask, go CS_SETUP.
//  - CS_SETUP: csn=0 for CLK_DIV cycles -> SHIFT.
//  - SHIFT: 16 SCLK periods. sclk low CLK_DIV, high CLK_DIV. MOSI updated at the fall; MISO sampled at the rise.
//  - CS_HOLD: CLK_DIV cycles after the last rise, then csn=1 -> GAP.
//  - GAP: CS_GAP cycles. If more frames remain -> CS_SETUP, else -> COMMIT.
//  - COMMIT (1 cycle): copy shadow, o_done=1, o_scan_cnt+1, o_busy=0 after this cycle.
//    Then: i_cont=1 -> CS_SETUP with a freshly latched mask (IDLE if the mask is 0); otherwise IDLE.
//  Boundary conditions
//  - i_start edge while busy: ignored, not queued.
//  - i_start edge with mask=0: ignored, no done pulse.
//  - i_ch_mask changes mid-scan: no effect until the next scan.
//  - i_cont drops mid-scan: the current scan completes and commits, then IDLE.
//  - Scan latency = (k+1)*(2*CLK_DIV + 32*CLK_DIV + CS_GAP) + 1 clk from start edge to o_done.
//    Start-edge detect adds 1 cycle.
// CONFIGURATION
//  ADC_AVG_EN defined
//  - Each scan runs its frame sequence 4 times back-to-back.
//  - Per-channel 18-bit accumulators; commit value = sum[17:2] (truncate).
//  - Latency is 4x; o_done and o_scan_cnt advance once per averaged scan.
//  ADC_AVG_EN undefined
//  - A single pass per scan, raw 16-bit results.
//  - No accumulator logic is synthesised.
// TESTING
//  1. Reset
//     - Stimulus: reset, then release.
//     - Response: csn=1, sclk=1, o_ch_data=0, o_scan_cnt=0, and no SPI activity for 1000 cycles.
//  2. Single 3-channel scan
//     - Stimulus: mask=0x0B, ADC model returns 0x1000+ch, i_start 0->1.
//     - Response: 4 frames with MOSI ch 0,1,3,0; o_ch_data[15:0]=0x1000, [31:16]=0x1001, [63:48]=0x1003.
//       Other channels = 0; one o_done; o_scan_cnt=1.
//  3. Timing (CLK_DIV=4, CS_GAP=8)
//     - Response: SCLK period 8 clk, csn-low to first fall 4 clk.
//     - Response: csn-high >= 8 clk; o_done at the latency formula.
//  4. Continuous mode
//     - Stimulus: i_cont=1, mask=0x80, ADC value increments per frame; run 300 scans, then drop i_cont.
//     - Response: o_scan_cnt wraps to 0x2C; the current scan finishes; then IDLE.
//  5. Ignored starts
//     - Stimulus: start edge while busy, and start edge with mask=0.
//     - Response: no extra frames, no o_done.
//     - Stimulus: mid-scan mask change 0x01->0x02.
//     - Response: only ch0 updated.
//  6. Reset mid-SHIFT, and averaging
//     - Reset mid-SHIFT: outputs return to reset values, o_ch_data unchanged from 0.
//     - With ADC_AVG_EN: ch0 samples 0x0004, 0x0005, 0x0006, 0x0008 -> o_ch_data[15:0]=0x0005.

Source files
------------

// File: rtl/adc_spi_scan.sv
// adc_spi_scan: SPI master that scans up to 8 channels of an external 16-bit ADC.
// Each frame sends {2'b00, ch[2:0], 11'b0} MSB first and receives the conversion
// addressed by the previous frame, so k enabled channels need k+1 frames per scan.
// Results collect in a shadow buffer and are copied to o_ch_data in a single
// commit cycle, so a multi-byte register read never mixes two scans.
// Optional build macro ADC_AVG_EN: each scan runs its frame sequence four times
// and commits the truncated average of the four samples per channel.
module adc_spi_scan #(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         i_start,
  input  logic         i_cont,
  input  logic [7:0]   i_ch_mask,
  output logic         spi_csn,
  output logic         spi_sclk,
  output logic         spi_mosi,
  input  logic         spi_miso,
  output logic         o_busy,
  output logic         o_done,
  output logic [7:0]   o_scan_cnt,
  output logic [127:0] o_ch_data
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CS_SETUP = 3'd1,
    SHIFT    = 3'd2,
    CS_HOLD  = 3'd3,
    GAP      = 3'd4,
    COMMIT   = 3'd5
  } state_t;

  // One cycle counter serves every timed state; size it for the longest of them.
  localparam int CW = $clog2((CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP) + 1;
  localparam logic [CW-1:0] DIV_END = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_END = CW'(CS_GAP - 1);

  state_t          state;
  logic [CW-1:0]   div_cnt;
  logic [3:0]      bit_cnt;
  logic [15:0]     rx_sr;
  logic [7:0]      mask_q;
  logic [2:0]      cmd_ch;     // channel commanded by the frame in flight
  logic [2:0]      prev_ch;    // channel commanded by the previous frame
  logic            first_frm;  // frame in flight returns a stale conversion
  logic            last_frm;   // frame in flight re-addresses the lowest channel
  logic            miso_s1;
  logic            miso_s2;
  logic            start_q;
  logic            start_pulse;
  logic            scan_go;
  logic [15:0]     cmd_word;
  logic [3:0]      nxt;

`ifdef ADC_AVG_EN
  logic [17:0]     acc [8];
  logic [1:0]      pass_cnt;
`else
  logic [15:0]     shadow [8];
`endif

  // Lowest set bit of a channel mask.
  function automatic logic [2:0] lowest_ch(input logic [7:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) r = 3'(i);
    end
    return r;
  endfunction

  // Next enabled channel above c; bit 3 flags that one exists.
  function automatic logic [3:0] next_ch(input logic [7:0] m, input logic [2:0] c);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i] && (3'(i) > c)) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  assign cmd_word = {2'b00, cmd_ch, 11'b0};
  assign nxt      = next_ch(mask_q, cmd_ch);

  // Bring the asynchronous ADC data line into the clk domain.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      miso_s1 <= 1'b0;
      miso_s2 <= 1'b0;
    end else begin
      miso_s1 <= spi_miso;
      miso_s2 <= miso_s1;
    end
  end

  // Registered rising-edge detect on the start level from the register block.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      start_q     <= 1'b0;
      start_pulse <= 1'b0;
    end else begin
      start_q     <= i_start;
      start_pulse <= i_start & ~start_q;
    end
  end

  // A scan begins from IDLE on a start edge, or straight after a commit in continuous mode.
  always_comb begin
    scan_go = 1'b0;
    if (i_ch_mask != 8'h00) begin
      if (state == IDLE && start_pulse) scan_go = 1'b1;
      if (state == COMMIT && i_cont)    scan_go = 1'b1;
    end
  end

  // Scan sequencer: SPI framing, channel ordering, shadow capture and commit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      spi_csn    <= 1'b1;
      spi_sclk   <= 1'b1;
      spi_mosi   <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_scan_cnt <= 8'h00;
      o_ch_data  <= '0;
      div_cnt    <= '0;
      bit_cnt    <= 4'd0;
      rx_sr      <= 16'h0000;
      mask_q     <= 8'h00;
      cmd_ch     <= 3'd0;
      prev_ch    <= 3'd0;
      first_frm  <= 1'b0;
      last_frm   <= 1'b0;
`ifdef ADC_AVG_EN
      pass_cnt   <= 2'd0;
      for (int n = 0; n < 8; n++) acc[n] <= 18'd0;
`else
      for (int n = 0; n < 8; n++) shadow[n] <= 16'h0000;
`endif
    end else begin
      o_done <= 1'b0;
      if (scan_go) begin
        state     <= CS_SETUP;
        spi_csn   <= 1'b0;
        o_busy    <= 1'b1;
        div_cnt   <= '0;
        mask_q    <= i_ch_mask;
        cmd_ch    <= lowest_ch(i_ch_mask);
        first_frm <= 1'b1;
        last_frm  <= 1'b0;
`ifdef ADC_AVG_EN
        pass_cnt  <= 2'd0;
        for (int n = 0; n < 8; n++) acc[n] <= 18'd0;
`endif
      end else begin
        case (state)
          IDLE: ;
          CS_SETUP: begin
            if (div_cnt == DIV_END) begin
              state    <= SHIFT;
              spi_sclk <= 1'b0;
              spi_mosi <= cmd_word[15];
              div_cnt  <= '0;
              bit_cnt  <= 4'd0;
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
          end
          SHIFT: begin
            if (div_cnt == DIV_END) begin
              div_cnt <= '0;
              if (!spi_sclk) begin
                spi_sclk <= 1'b1;
                rx_sr    <= {rx_sr[14:0], miso_s2};
              end else if (bit_cnt == 4'd15) begin
                state <= CS_HOLD;
              end else begin
                spi_sclk <= 1'b0;
                spi_mosi <= cmd_word[4'd14 - bit_cnt];
                bit_cnt  <= bit_cnt + 4'd1;
              end
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
          end
          CS_HOLD: begin
            if (div_cnt == DIV_END) begin
              state   <= GAP;
              spi_csn <= 1'b1;
              div_cnt <= '0;
              // The word just received belongs to the channel commanded one frame earlier.
              if (!first_frm) begin
`ifdef ADC_AVG_EN
                acc[prev_ch] <= acc[prev_ch] + {2'b00, rx_sr};
`else
                shadow[prev_ch] <= rx_sr;
`endif
              end
              prev_ch   <= cmd_ch;
              first_frm <= 1'b0;
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
          end
          GAP: begin
            if (div_cnt == GAP_END) begin
              div_cnt <= '0;
              if (!last_frm) begin
                state   <= CS_SETUP;
                spi_csn <= 1'b0;
                if (nxt[3]) begin
                  cmd_ch <= nxt[2:0];
                end else begin
                  cmd_ch   <= lowest_ch(mask_q);
                  last_frm <= 1'b1;
                end
`ifdef ADC_AVG_EN
              end else if (pass_cnt != 2'd3) begin
                // Restart the frame sequence for the next averaging pass.
                pass_cnt  <= pass_cnt + 2'd1;
                state     <= CS_SETUP;
                spi_csn   <= 1'b0;
                cmd_ch    <= lowest_ch(mask_q);
                first_frm <= 1'b1;
                last_frm  <= 1'b0;
`endif
              end else begin
                state      <= COMMIT;
                o_done     <= 1'b1;
                o_scan_cnt <= o_scan_cnt + 8'd1;
                for (int n = 0; n < 8; n++) begin
                  if (mask_q[n]) begin
`ifdef ADC_AVG_EN
                    o_ch_data[16*n +: 16] <= acc[n][17:2];
`else
                    o_ch_data[16*n +: 16] <= shadow[n];
`endif
                  end
                end
              end
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
          end
          COMMIT: begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
